// File: rtl/psum_drain_ctrl.sv
// Drains packed partial sums from the accumulator memory, applies optional per-lane
// ReLU, streams the words out on valid/ready and zeroes each location behind the read.
module psum_drain_ctrl #(
   parameter int BIT_WIDTH  = 8,
   parameter int NUM_KERNEL = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int REG_WIDTH  = 32,
   parameter int MEM_DELAY  = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_start,
   input  logic [REG_WIDTH-1:0]  i_conf_drainlen,
   input  logic                  i_conf_relu_en,
   output logic [ADDR_WIDTH-1:0] mem_radd,
   output logic                  mem_rden,
   input  logic [DATA_WIDTH-1:0] mem_odat,
   input  logic                  mem_ovld,
   output logic [ADDR_WIDTH-1:0] mem_wadd,
   output logic                  mem_wren,
   output logic [DATA_WIDTH-1:0] mem_idat,
   output logic [DATA_WIDTH-1:0] o_dat,
   output logic                  o_vld,
   input  logic                  i_rdy,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [REG_WIDTH-1:0]  dbg_drain_rd_addr
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   if (FIFO_DEPTH < MEM_DELAY + 2) begin : g_depth_chk
      $error("FIFO_DEPTH must be at least MEM_DELAY+2");
   end
   if (DATA_WIDTH != BIT_WIDTH * NUM_KERNEL) begin : g_width_chk
      $error("DATA_WIDTH must equal BIT_WIDTH*NUM_KERNEL");
   end

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, clr_addr_q, drainlen_q, wadd_q;
   logic                  relu_q, wren_q;
   logic [CW-1:0]         inflight_q, count_q;
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] push_dat;
   logic [CW:0]           credit_used;
   logic                  accept, pop, rden, last_read;

   // Returns are only meaningful while a drain is active; stale ones after reset are dropped.
   assign accept      = mem_ovld && (state_q != S_IDLE);
   assign pop         = (count_q != '0) && i_rdy;
   assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
   assign rden        = (state_q == S_DRAIN) && (credit_used < (CW+1)'(FIFO_DEPTH));
   assign last_read   = rden && (rd_addr_q == drainlen_q);

   for (genvar gi = 0; gi < NUM_KERNEL; gi++) begin : g_lane
      logic [BIT_WIDTH-1:0] lane;
      assign lane = mem_odat[BIT_WIDTH*gi +: BIT_WIDTH];
      assign push_dat[BIT_WIDTH*gi +: BIT_WIDTH] = (relu_q && lane[BIT_WIDTH-1]) ? '0 : lane;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_start) state_d = S_DRAIN;
         S_DRAIN: if (last_read) state_d = S_FLUSH;
         S_FLUSH: if (inflight_q == '0 && count_q == '0 && !wren_q) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         rd_addr_q  <= '0;
         clr_addr_q <= '0;
         drainlen_q <= '0;
         relu_q     <= 1'b0;
         wren_q     <= 1'b0;
         wadd_q     <= '0;
         inflight_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_IDLE && i_start) begin
            rd_addr_q  <= '0;
            clr_addr_q <= '0;
            drainlen_q <= ADDR_WIDTH'(i_conf_drainlen);
            relu_q     <= i_conf_relu_en;
         end else begin
            if (rden)   rd_addr_q  <= rd_addr_q + 1'b1;
            if (accept) clr_addr_q <= clr_addr_q + 1'b1;
         end
         wren_q <= accept;
         wadd_q <= clr_addr_q;
         case ({rden, accept})
            2'b10:   inflight_q <= inflight_q + CW'(1);
            2'b01:   inflight_q <= inflight_q - CW'(1);
            default: ;
         endcase
         case ({accept, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
         if (accept) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
         if (pop)    rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) fifo_mem[wr_ptr_q] <= push_dat;
   end

   assign mem_radd          = rd_addr_q;
   assign mem_rden          = rden;
   assign mem_wadd          = wadd_q;
   assign mem_wren          = wren_q;
   assign mem_idat          = '0;
   assign o_vld             = (count_q != '0);
   assign o_dat             = o_vld ? fifo_mem[rd_ptr_q] : '0;
   assign o_busy            = (state_q != S_IDLE);
   assign o_done            = (state_q == S_DONE);
   assign dbg_drain_rd_addr = REG_WIDTH'(rd_addr_q);

endmodule

// File: tb/tb_psum_drain_ctrl.sv
// Bench for psum_drain_ctrl: a latency-accurate memory model plus a word-stream
// reference (expected outputs, clears and done) derived from the drain rules.
module tb_psum_drain_ctrl;
   localparam int MEM_DELAY  = 2;
   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_conf_relu_en = 1'b0;
   logic [31:0] i_conf_drainlen = '0;
   logic [31:0] mem_radd, mem_odat = '0, mem_wadd, mem_idat, o_dat, dbg_drain_rd_addr;
   logic        mem_rden, mem_ovld = 1'b0, mem_wren, o_vld, i_rdy = 1'b0, o_busy, o_done;

   psum_drain_ctrl #(.MEM_DELAY(MEM_DELAY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_conf_drainlen(i_conf_drainlen),
      .i_conf_relu_en(i_conf_relu_en), .mem_radd(mem_radd), .mem_rden(mem_rden),
      .mem_odat(mem_odat), .mem_ovld(mem_ovld), .mem_wadd(mem_wadd), .mem_wren(mem_wren),
      .mem_idat(mem_idat), .o_dat(o_dat), .o_vld(o_vld), .i_rdy(i_rdy), .o_busy(o_busy),
      .o_done(o_done), .dbg_drain_rd_addr(dbg_drain_rd_addr));

   always #5 clk = ~clk;

   typedef struct { int due; logic [31:0] data; } rd_t;
   typedef struct { logic [31:0] word; bit relu; logic [31:0] exp; } relu_vec_t;
   typedef struct { int dl; bit relu; int mode; bit inject; int exp_words; } drain_vec_t;

   int n_checks = 0, n_fail = 0;
   int cyc = 0;
   logic [31:0] mem_model [256];
   rd_t rq[$];
   logic [31:0] exp_q[$];
   int n_rd, n_out, n_clr, n_done, max_out, cur_dl, rdy_mode, stall_left;
   int rd_cyc [256], out_cyc [256], clr_cyc [256];
   bit first_seen, inject_flush, injected, hold_pend, start_req, rst_req, conf_relu;
   logic [31:0] hold_dat, last_out, conf_dl;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // A lane is cleared when ReLU is on and its signed value is negative.
   function automatic logic [31:0] relu_ref(input logic [31:0] w, input bit en);
      logic [31:0] r;
      logic signed [7:0] lane;
      r = w;
      for (int k = 0; k < 4; k++) begin
         lane = w[8*k +: 8];
         if (en && lane < 0) r[8*k +: 8] = 8'h00;
      end
      return r;
   endfunction

   task automatic step();
      rd_t r;
      @(negedge clk);
      cyc++;
      rst = rst_req;
      if (start_req) begin
         i_start = 1'b1; i_conf_drainlen = conf_dl; i_conf_relu_en = conf_relu; start_req = 1'b0;
      end else begin
         i_start = 1'b0; i_conf_drainlen = $urandom; i_conf_relu_en = 1'($urandom_range(0, 1));
      end
      if (rq.size() != 0 && rq[0].due == cyc) begin
         mem_ovld = 1'b1; mem_odat = rq[0].data; void'(rq.pop_front());
      end else begin
         mem_ovld = 1'b0; mem_odat = $urandom;
      end
      #1;
      if (hold_pend) begin
         chk("hold_vld", o_vld, 1);
         chk("hold_dat", o_dat, hold_dat);
      end
      case (rdy_mode)
         1: i_rdy = 1'($urandom_range(0, 1));
         2: begin
            if (o_vld === 1'b1 && !first_seen) begin first_seen = 1; stall_left = 10; end
            if (stall_left > 0) begin i_rdy = 1'b0; stall_left--; end else i_rdy = 1'b1;
         end
         default: i_rdy = 1'b1;
      endcase
      #1;
      if (mem_rden === 1'b1) begin
         chk("rd_addr", mem_radd, n_rd);
         if (n_rd < 256) rd_cyc[n_rd] = cyc;
         r.due = cyc + MEM_DELAY; r.data = mem_model[mem_radd[7:0]];
         rq.push_back(r);
         n_rd++;
      end
      if (n_rd - n_out > max_out) max_out = n_rd - n_out;
      if (mem_wren === 1'b1) begin
         chk("clr_addr", mem_wadd, n_clr);
         chk("clr_data", mem_idat, 0);
         mem_model[mem_wadd[7:0]] = '0;
         if (n_clr < 256) clr_cyc[n_clr] = cyc;
         n_clr++;
      end
      if (o_vld === 1'b1 && i_rdy) begin
         if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL extra_output: got %0h, required no output (cycle %0d)", o_dat, cyc);
         end else chk("out_data", o_dat, exp_q.pop_front());
         last_out = o_dat;
         if (n_out < 256) out_cyc[n_out] = cyc;
         n_out++;
      end
      hold_pend = (o_vld === 1'b1) && !i_rdy;
      hold_dat  = o_dat;
      if (o_done === 1'b1) n_done++;
      if (inject_flush && !injected && n_rd == cur_dl + 1) begin start_req = 1; injected = 1; end
   endtask

   task automatic prep_drain(input int dl, input bit relu, input int mode, input bit inject);
      cur_dl = dl; n_rd = 0; n_out = 0; n_clr = 0; n_done = 0; max_out = 0;
      first_seen = 0; stall_left = 0; rdy_mode = mode; inject_flush = inject; injected = 0;
      hold_pend = 0;
      exp_q.delete();
      for (int a = 0; a <= dl; a++) exp_q.push_back(relu_ref(mem_model[a], relu));
      conf_dl = dl; conf_relu = relu; start_req = 1;
   endtask

   task automatic run_drain(input int dl, input bit relu, input int mode, input bit inject,
                            input int exp_words, output int s_cyc);
      int guard, nz;
      prep_drain(dl, relu, mode, inject);
      step();
      s_cyc = cyc;
      step();
      chk("busy_after_start", o_busy, 1);
      guard = 0;
      while (n_done == 0 && guard < 400) begin step(); guard++; end
      chk("drain_completes", n_done != 0, 1);
      repeat (4) step();
      chk("n_reads", n_rd, exp_words);
      chk("n_outputs", n_out, exp_words);
      chk("n_clears", n_clr, exp_words);
      chk("n_done", n_done, 1);
      chk("exp_left", exp_q.size(), 0);
      chk("busy_after_done", o_busy, 0);
      chk("dbg_rd_addr", dbg_drain_rd_addr, exp_words);
      chk("credit_bound", max_out <= FIFO_DEPTH, 1);
      nz = 0;
      for (int a = 0; a < exp_words; a++) if (mem_model[a] != 0) nz++;
      chk("mem_clean", nz, 0);
   endtask

   relu_vec_t  rv [5];
   drain_vec_t dv [5];

   initial begin
      int s_cyc;
      rv[0] = '{32'h80FF7F01, 1'b1, 32'h00007F01};
      rv[1] = '{32'h80FF7F01, 1'b0, 32'h80FF7F01};
      rv[2] = '{32'hFFFFFFFF, 1'b1, 32'h00000000};
      rv[3] = '{32'h7F7F7F7F, 1'b1, 32'h7F7F7F7F};
      rv[4] = '{32'h01800280, 1'b1, 32'h01000200};
      dv[0] = '{3, 1'b0, 0, 1'b0, 4};
      dv[1] = '{9, 1'b0, 2, 1'b0, 10};
      dv[2] = '{0, 1'b1, 0, 1'b0, 1};
      dv[3] = '{5, 1'b0, 0, 1'b1, 6};
      dv[4] = '{7, 1'b1, 1, 1'b0, 8};
      rst_req = 1; start_req = 0; rdy_mode = 0; hold_pend = 0; inject_flush = 0;
      n_rd = 0; n_out = 0; n_clr = 0; n_done = 0; max_out = 0; cur_dl = 0;
      for (int i = 0; i < 256; i++) mem_model[i] = 32'h04030201 + i;

      repeat (3) step();
      rst_req = 0;
      step();
      chk("rst_rden", mem_rden, 0);   chk("rst_radd", mem_radd, 0);
      chk("rst_wren", mem_wren, 0);   chk("rst_wadd", mem_wadd, 0);
      chk("rst_vld", o_vld, 0);       chk("rst_dat", o_dat, 0);
      chk("rst_busy", o_busy, 0);     chk("rst_done", o_done, 0);
      chk("rst_dbg", dbg_drain_rd_addr, 0);

      foreach (dv[i]) begin
         for (int a = 0; a < 256; a++) mem_model[a] = 32'h04030201 + a;
         run_drain(dv[i].dl, dv[i].relu, dv[i].mode, dv[i].inject, dv[i].exp_words, s_cyc);
         if (dv[i].mode == 0) begin
            for (int k = 0; k < dv[i].exp_words; k++) begin
               chk("rd_cycle", rd_cyc[k], s_cyc + 1 + k);
               chk("out_latency", out_cyc[k], rd_cyc[k] + MEM_DELAY + 1);
               chk("clr_cycle", clr_cyc[k], rd_cyc[k] + MEM_DELAY + 1);
            end
         end
         if (dv[i].mode == 2) chk("credits_used", max_out, FIFO_DEPTH);
         $display("drain dl=%0d relu=%0d mode=%0d inject=%0d outputs=%0d", dv[i].dl,
                  dv[i].relu, dv[i].mode, dv[i].inject, n_out);
      end

      foreach (rv[i]) begin
         mem_model[0] = rv[i].word;
         run_drain(0, rv[i].relu, 0, 1'b0, 1, s_cyc);
         chk("relu_vec", last_out, rv[i].exp);
         $display("relu word=%h en=%0d out=%h", rv[i].word, rv[i].relu, last_out);
      end

      // Reset with two reads outstanding: late returns must not surface.
      for (int a = 0; a < 256; a++) mem_model[a] = 32'h04030201 + a;
      prep_drain(9, 1'b0, 0, 1'b0);
      step();
      step();
      rst_req = 1;
      step();
      rst_req = 0;
      exp_q.delete();
      step();
      chk("rst_mid_rden", mem_rden, 0);  chk("rst_mid_vld", o_vld, 0);
      chk("rst_mid_wren", mem_wren, 0);  chk("rst_mid_busy", o_busy, 0);
      chk("rst_mid_radd", mem_radd, 0);  chk("rst_mid_dat", o_dat, 0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("late_ovld_vld", o_vld, 0);
         chk("late_ovld_wren", mem_wren, 0);
      end
      $display("reset mid-drain: reads=%0d outputs=%0d clears=%0d", n_rd, n_out, n_clr);

      for (int t = 0; t < 10; t++) begin
         int dl;
         bit relu;
         dl = $urandom_range(0, 20);
         relu = 1'($urandom_range(0, 1));
         for (int a = 0; a < 32; a++) mem_model[a] = $urandom;
         run_drain(dl, relu, 1, 1'b0, dl + 1, s_cyc);
         $display("random drain dl=%0d relu=%0d outputs=%0d", dl, relu, n_out);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
